// File: rtl/table_fsm_pkg.sv
// Shared definitions for the table-driven FSM: default geometry and table entry layout.
// The bench and any table loader pack entries with the same helpers.
package table_fsm_pkg;

    localparam int DEF_SW = 3;
    localparam int DEF_IW = 2;
    localparam int DEF_OW = 3;
    localparam int DEF_CW = 16;

    // Number of table entries for a given state/input width.
    function automatic int tbl_depth(input int sw, input int iw);
        return 1 << (sw + iw);
    endfunction

    // Entry layout is {next_state, out}; these give the bit positions of each field.
    function automatic int nxt_lsb(input int ow);
        return ow;
    endfunction

    function automatic int out_msb(input int ow);
        return ow - 1;
    endfunction

endpackage

// File: rtl/fsm_table_ram.sv
// Transition table storage: one write port, one asynchronous read port, and a
// per-entry valid vector that is cleared by reset while the data array is not.
module fsm_table_ram
    import table_fsm_pkg::*;
#(
    parameter int AW = DEF_SW + DEF_IW,
    parameter int DW = DEF_SW + DEF_OW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;

    // A write coinciding with reset is dropped so data and valid bit stay consistent.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                end else if (we && (waddr == AW'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign rdata  = mem[raddr];
    assign rvalid = valid_reg[raddr];

endmodule

// File: rtl/table_fsm.sv
// Programmable FSM whose next state and output come from a RAM indexed by {state, a}.
// Supports Moore (registered) or Mealy (combinational) output, sticky error and step count.
module table_fsm
    import table_fsm_pkg::*;
#(
    parameter int          SW          = DEF_SW,
    parameter int          IW          = DEF_IW,
    parameter int          OW          = DEF_OW,
    parameter int unsigned RESET_STATE = 0,
    parameter bit          MEALY       = 1'b0,
    parameter int          CW          = DEF_CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [IW-1:0]    a,
    input  logic             cfg_we,
    input  logic [SW+IW-1:0] cfg_addr,
    input  logic [SW+OW-1:0] cfg_data,
    output logic [SW-1:0]    state,
    output logic [OW-1:0]    saida,
    output logic             err,
    output logic [CW-1:0]    steps
);

    localparam int AW = SW + IW;
    localparam int DW = SW + OW;
    localparam int NXT_LSB = nxt_lsb(OW);
    localparam int OUT_MSB = out_msb(OW);

    logic [SW-1:0] state_reg;
    logic          err_reg;
    logic [CW-1:0] steps_reg;

    logic [AW-1:0] idx;
    logic [DW-1:0] entry;
    logic          entry_valid;
    logic [SW-1:0] entry_nxt;
    logic [OW-1:0] entry_out;
    logic          take_step;

    assign idx       = {state_reg, a};
    assign entry_nxt = entry[DW-1:NXT_LSB];
    assign entry_out = entry[OUT_MSB:0];
    assign take_step = en && entry_valid;

    // Async read means a same-cycle write to idx is only visible after the edge.
    fsm_table_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (cfg_we),
        .waddr  (cfg_addr),
        .wdata  (cfg_data),
        .raddr  (idx),
        .rdata  (entry),
        .rvalid (entry_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SW'(RESET_STATE);
            err_reg   <= 1'b0;
            steps_reg <= '0;
        end else begin
            if (take_step) begin
                state_reg <= entry_nxt;
                if (steps_reg != {CW{1'b1}}) begin
                    steps_reg <= steps_reg + CW'(1);
                end
            end
            if (en && !entry_valid) begin
                err_reg <= 1'b1;
            end
        end
    end

    generate
        if (MEALY) begin : g_mealy
            assign saida = entry_valid ? entry_out : '0;
        end else begin : g_moore
            logic [OW-1:0] saida_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    saida_reg <= '0;
                end else if (take_step) begin
                    saida_reg <= entry_out;
                end
            end
            assign saida = saida_reg;
        end
    endgenerate

    assign state = state_reg;
    assign err   = err_reg;
    assign steps = steps_reg;

endmodule

// File: tb/tb_table_fsm.sv
// Directed bench for table_fsm: Moore, Mealy and narrow-counter instances share stimulus
// so one walk through the table exercises all three configurations.
module tb_table_fsm;
    import table_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] a;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [5:0] cfg_data;

    logic [2:0]  state_m, state_y, state_c;
    logic [2:0]  saida_m, saida_y, saida_c;
    logic        err_m, err_y, err_c;
    logic [15:0] steps_m, steps_y;
    logic [1:0]  steps_c;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    table_fsm #(.MEALY(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .a(a), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .state(state_m), .saida(saida_m), .err(err_m), .steps(steps_m)
    );

    table_fsm #(.MEALY(1'b1)) dut_mealy (
        .clk(clk), .reset(reset), .en(en), .a(a), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .state(state_y), .saida(saida_y), .err(err_y), .steps(steps_y)
    );

    table_fsm #(.CW(2)) dut_cw (
        .clk(clk), .reset(reset), .en(en), .a(a), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .state(state_c), .saida(saida_c), .err(err_c), .steps(steps_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] st, input logic [1:0] in,
                               input logic [2:0] nxt, input logic [2:0] out);
        cfg_we   = 1'b1;
        cfg_addr = {st, in};
        cfg_data = {nxt, out};
        tick();
        cfg_we   = 1'b0;
    endtask

    // Expected Moore sequence for the 0->1->2->0 table with a=0.
    logic [2:0] exp_seq [6] = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};

    initial begin
        reset = 1'b1; en = 1'b0; a = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset_state", state_m, 0);
        check("reset_saida", saida_m, 0);
        check("reset_err",   err_m, 0);
        check("reset_steps", steps_m, 0);

        // Step on an empty table: state holds, err latches.
        en = 1'b1; a = 2'd0;
        tick();
        en = 1'b0;
        check("empty_state", state_m, 0);
        check("empty_err",   err_m, 1);
        check("empty_steps", steps_m, 0);
        check("empty_saida", saida_m, 0);

        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_clears_err", err_m, 0);

        write_entry(3'd0, 2'd0, 3'd1, 3'd1);
        write_entry(3'd1, 2'd0, 3'd2, 3'd2);
        write_entry(3'd2, 2'd0, 3'd0, 3'd0);

        en = 1'b1; a = 2'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("run_state%0d", i), state_m, exp_seq[i]);
            check($sformatf("run_saida%0d", i), saida_m, exp_seq[i]);
        end
        check("run_steps",  steps_m, 6);
        check("run_err",    err_m, 0);
        check("cw_sat",     steps_c, 3);
        check("mealy_state", state_y, 0);

        // Move to state 1, then probe the Mealy output combinationally.
        tick();
        en = 1'b0;
        check("to1_state", state_m, 1);
        a = 2'd0; #1;
        check("mealy_a0", saida_y, 2);
        a = 2'd1; #1;
        check("mealy_a1_unprog", saida_y, 0);
        check("moore_hold", saida_m, 1);
        tick();
        check("en0_no_err", err_m, 0);

        // en toggled 1,0,1 starting from state 1.
        a = 2'd0;
        en = 1'b1; tick();
        check("tog1_state", state_m, 2);
        check("tog1_steps", steps_m, 8);
        en = 1'b0; tick();
        check("tog0_state", state_m, 2);
        check("tog0_steps", steps_m, 8);
        en = 1'b1; tick();
        check("tog2_state", state_m, 0);
        check("tog2_steps", steps_m, 9);
        tick();
        check("pre_wr_state", state_m, 1);

        // Rewrite entry {1,0} while stepping through it: old contents apply.
        cfg_we = 1'b1; cfg_addr = {3'd1, 2'd0}; cfg_data = {3'd3, 3'd7};
        tick();
        cfg_we = 1'b0;
        check("wr_same_state", state_m, 2);
        check("wr_same_saida", saida_m, 2);
        tick(); tick();
        check("revisit_state", state_m, 1);
        tick();
        check("new_entry_state", state_m, 3);
        check("new_entry_saida", saida_m, 7);
        check("new_entry_steps", steps_m, 14);
        check("mealy_unprog3", saida_y, 0);
        tick();
        en = 1'b0;
        check("s3_hold_state", state_m, 3);
        check("s3_err",        err_m, 1);
        check("s3_hold_steps", steps_m, 14);
        check("s3_hold_saida", saida_m, 7);
        check("s3_mealy_err",  err_y, 1);

        // Reset together with a write: write dropped, valid bits cleared.
        reset = 1'b1; en = 1'b1;
        cfg_we = 1'b1; cfg_addr = {3'd0, 2'd0}; cfg_data = {3'd2, 3'd5};
        tick();
        reset = 1'b0; en = 1'b0; cfg_we = 1'b0;
        check("rw_state",   state_m, 0);
        check("rw_steps",   steps_m, 0);
        check("rw_steps_c", steps_c, 0);
        check("rw_err",     err_m, 0);
        check("rw_saida",   saida_m, 0);
        a = 2'd0; #1;
        check("rw_mealy_invalid", saida_y, 0);
        en = 1'b1; tick(); en = 1'b0;
        check("rw_step_state", state_m, 0);
        check("rw_step_err",   err_m, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
